// File: rtl/onehot_encoder_pipe.sv
// Registered one-hot / priority encoder with a single-stage valid/ready output register.
// Flags zero and multi-hot words and keeps a saturating count of words invalid for MODE.
module onehot_encoder_pipe #(
  parameter int WIDTH  = 8,
  parameter int CODE_W = $clog2(WIDTH),
  parameter int MODE   = 0,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_zero,
  output logic              out_multi,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              err_clr
);

  generate
    if (MODE < 0 || MODE > 2) begin : g_bad_mode
      $error("onehot_encoder_pipe: MODE must be 0, 1 or 2");
    end
    if (WIDTH < 2) begin : g_bad_width
      $error("onehot_encoder_pipe: WIDTH must be >= 2");
    end
  endgenerate

  logic              out_valid_q, out_valid_d;
  logic [CODE_W-1:0] out_code_q, out_code_d;
  logic              out_zero_q, out_zero_d;
  logic              out_multi_q, out_multi_d;
  logic              out_err_q, out_err_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic              zero, multi, seen, accept;
  logic [CODE_W-1:0] lsb_code, msb_code, code_c;
  logic              err_c;

  // Scan both directions; codes only ever take indices of real bits, so
  // unused codes of a non-power-of-2 WIDTH cannot appear.
  always_comb begin
    lsb_code = '0;
    msb_code = '0;
    seen     = 1'b0;
    multi    = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_data[i]) begin
        if (seen) multi = 1'b1;
        seen     = 1'b1;
        msb_code = CODE_W'(i);
      end
    end
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in_data[i]) lsb_code = CODE_W'(i);
    end
    zero = ~|in_data;
  end

  always_comb begin
    code_c = '0;
    err_c  = zero;
    if (MODE == 0) begin
      err_c  = zero | multi;
      code_c = (zero | multi) ? '0 : lsb_code;
    end else if (MODE == 1) begin
      code_c = lsb_code;
    end else begin
      code_c = msb_code;
    end
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_zero_d  = out_zero_q;
    out_multi_d = out_multi_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_code_d  = code_c;
      out_zero_d  = zero;
      out_multi_d = multi;
      out_err_d   = err_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // Clear wins over a coincident increment.
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (accept && err_c && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_zero_q  <= 1'b0;
      out_multi_q <= 1'b0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_zero_q  <= out_zero_d;
      out_multi_q <= out_multi_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_zero  = out_zero_q;
  assign out_multi = out_multi_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Directed bench: four encoder instances (MODE 0/1/2 and a 2-bit counter variant)
// share one stimulus stream; each scenario task checks the instance it targets.
module tb_onehot_encoder_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready, err_clr;
  logic [7:0] in_data;

  logic       ir [4];
  logic       ov [4];
  logic [2:0] oc [4];
  logic       oz [4];
  logic       om [4];
  logic       oe [4];
  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  onehot_encoder_pipe #(.WIDTH(8), .MODE(0), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_code(oc[0]), .out_zero(oz[0]),
    .out_multi(om[0]), .out_err(oe[0]), .err_cnt(cnt0), .err_clr(err_clr));
  onehot_encoder_pipe #(.WIDTH(8), .MODE(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_code(oc[1]), .out_zero(oz[1]),
    .out_multi(om[1]), .out_err(oe[1]), .err_cnt(cnt1), .err_clr(err_clr));
  onehot_encoder_pipe #(.WIDTH(8), .MODE(2), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_code(oc[2]), .out_zero(oz[2]),
    .out_multi(om[2]), .out_err(oe[2]), .err_cnt(cnt2), .err_clr(err_clr));
  onehot_encoder_pipe #(.WIDTH(8), .MODE(0), .CNT_W(2)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .in_data(in_data),
    .out_valid(ov[3]), .out_ready(out_ready), .out_code(oc[3]), .out_zero(oz[3]),
    .out_multi(om[3]), .out_err(oe[3]), .err_cnt(cnt3), .err_clr(err_clr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0; in_data = 8'h00;
    tick(); tick();
    chk_cnt++; if (ov[0] !== 1'b0) $display("FAIL rst_valid: got %b want 0", ov[0]); else pass_cnt++;
    chk_cnt++; if (cnt0 !== 8'd0) $display("FAIL rst_cnt: got %0d want 0", cnt0); else pass_cnt++;
    rst = 1'b0;
    // Park a result with back-pressure, then reset mid-transfer.
    in_valid = 1'b1; in_data = 8'h24;
    tick();
    in_valid = 1'b0;
    chk_cnt++; if (ov[0] !== 1'b1 || om[0] !== 1'b1 || cnt0 !== 8'd1)
      $display("FAIL pre_rst_held: got v=%b m=%b cnt=%0d want v=1 m=1 cnt=1", ov[0], om[0], cnt0); else pass_cnt++;
    chk_cnt++; if (oc[2] !== 3'd5) $display("FAIL pre_rst_code: got %0d want 5", oc[2]); else pass_cnt++;
    #3 rst = 1'b1;
    #1;
    chk_cnt++; if (ov[0] !== 1'b0 || om[0] !== 1'b0 || oe[0] !== 1'b0 || oz[0] !== 1'b0 || oc[0] !== 3'd0)
      $display("FAIL async_rst_flags: got v=%b m=%b e=%b z=%b c=%0d want all 0", ov[0], om[0], oe[0], oz[0], oc[0]); else pass_cnt++;
    chk_cnt++; if (oc[2] !== 3'd0 || cnt0 !== 8'd0)
      $display("FAIL async_rst_code_cnt: got c=%0d cnt=%0d want 0 0", oc[2], cnt0); else pass_cnt++;
    tick();
    rst = 1'b0;
    #1;
    chk_cnt++; if (ir[0] !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", ir[0]); else pass_cnt++;
  endtask

  task automatic test_sweep();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h01 << i;
      tick();
      chk_cnt++; if (ov[0] !== 1'b1 || oc[0] !== 3'(i) || oe[0] !== 1'b0 || ir[0] !== 1'b1)
        $display("FAIL sweep_%0d: got v=%b c=%0d e=%b rdy=%b want v=1 c=%0d e=0 rdy=1", i, ov[0], oc[0], oe[0], ir[0], i);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    tick();
    chk_cnt++; if (ov[0] !== 1'b0) $display("FAIL drain_valid: got %b want 0", ov[0]); else pass_cnt++;
  endtask

  task automatic test_invalid();
    in_valid = 1'b1; in_data = 8'h00;
    tick();
    chk_cnt++; if (oc[0] !== 3'd0 || oz[0] !== 1'b1 || om[0] !== 1'b0 || oe[0] !== 1'b1)
      $display("FAIL m0_zero: got c=%0d z=%b m=%b e=%b want c=0 z=1 m=0 e=1", oc[0], oz[0], om[0], oe[0]); else pass_cnt++;
    chk_cnt++; if (oc[1] !== 3'd0 || oe[1] !== 1'b1 || oc[2] !== 3'd0 || oe[2] !== 1'b1)
      $display("FAIL m12_zero: got c1=%0d e1=%b c2=%0d e2=%b want 0 1 0 1", oc[1], oe[1], oc[2], oe[2]); else pass_cnt++;
    in_data = 8'h24;
    tick();
    in_valid = 1'b0;
    chk_cnt++; if (oc[0] !== 3'd0 || oz[0] !== 1'b0 || om[0] !== 1'b1 || oe[0] !== 1'b1)
      $display("FAIL m0_multi: got c=%0d z=%b m=%b e=%b want c=0 z=0 m=1 e=1", oc[0], oz[0], om[0], oe[0]); else pass_cnt++;
    chk_cnt++; if (cnt0 !== 8'd2) $display("FAIL m0_err_cnt: got %0d want 2", cnt0); else pass_cnt++;
  endtask

  task automatic test_priority();
    in_valid = 1'b1; in_data = 8'h24;
    tick();
    chk_cnt++; if (oc[1] !== 3'd2 || om[1] !== 1'b1 || oe[1] !== 1'b0)
      $display("FAIL lsb_24: got c=%0d m=%b e=%b want c=2 m=1 e=0", oc[1], om[1], oe[1]); else pass_cnt++;
    chk_cnt++; if (oc[2] !== 3'd5 || om[2] !== 1'b1 || oe[2] !== 1'b0)
      $display("FAIL msb_24: got c=%0d m=%b e=%b want c=5 m=1 e=0", oc[2], om[2], oe[2]); else pass_cnt++;
    in_data = 8'h81;
    tick();
    in_valid = 1'b0;
    chk_cnt++; if (oc[1] !== 3'd0 || oc[2] !== 3'd7)
      $display("FAIL prio_81: got lsb=%0d msb=%0d want 0 7", oc[1], oc[2]); else pass_cnt++;
    tick();
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_data = 8'h08; out_ready = 1'b0;
    tick();
    in_data = 8'h10;
    for (int i = 0; i < 3; i++) begin
      chk_cnt++; if (ir[0] !== 1'b0 || ov[0] !== 1'b1 || oc[0] !== 3'd3)
        $display("FAIL bp_hold_%0d: got rdy=%b v=%b c=%0d want rdy=0 v=1 c=3", i, ir[0], ov[0], oc[0]);
      else pass_cnt++;
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk_cnt++; if (ir[0] !== 1'b1) $display("FAIL bp_release_rdy: got %b want 1", ir[0]); else pass_cnt++;
    tick();
    in_valid = 1'b0;
    chk_cnt++; if (ov[0] !== 1'b1 || oc[0] !== 3'd4)
      $display("FAIL bp_next_word: got v=%b c=%0d want v=1 c=4", ov[0], oc[0]); else pass_cnt++;
    tick();
  endtask

  task automatic test_saturate();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk_cnt++; if (cnt3 !== 2'd0) $display("FAIL sat_clr_idle: got %0d want 0", cnt3); else pass_cnt++;
    in_valid = 1'b1; in_data = 8'h03; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk_cnt++; if (cnt3 !== 2'd3) $display("FAIL sat_stick: got %0d want 3", cnt3); else pass_cnt++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0; in_valid = 1'b0;
    chk_cnt++; if (cnt3 !== 2'd0 || oe[3] !== 1'b1)
      $display("FAIL sat_clr_prio: got cnt=%0d e=%b want cnt=0 e=1", cnt3, oe[3]); else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_invalid();
    test_priority();
    test_backpressure();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
